muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Sequences the shared multiplier/divider resource for the multicycle control unit (MULT/DIV).
//  Issues init pulses, waits on done, commits HI/LO, flags divide-by-zero and hung units.
//  Sits between the control FSM (start/abort/busy) and the mult, div and HI/LO registers.
//  The control unit stalls while busy=1.
// PARAMETERS
//  TIMEOUT  64  max cycles in a WAIT state before timeout_err (>=2)
//  CNT_W    7   wait-counter width; 2**CNT_W > TIMEOUT
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   synchronous, active-low reset
//  start_mult   in   1   request MULT; sampled only in IDLE
//  start_div    in   1   request DIV; sampled only in IDLE
//  b_value      in   32  divisor (B register), sampled with start_div
//  abort        in   1   exception flush; cancels any in-flight op
//  mult_done    in   1   multiplier result valid
//  div_done     in   1   divider result valid
//  init_mult    out  1   1-cycle start pulse to multiplier
//  init_div     out  1   1-cycle start pulse to divider
//  hi_write     out  1   HI register load enable
//  lo_write     out  1   LO register load enable
//  busy         out  1   1 in every state except IDLE
//  op_done      out  1   1-cycle pulse: result committed
//  div_by_zero  out  1   1-cycle pulse: DIV with b_value==0 rejected
//  timeout_err  out  1   1-cycle pulse: unit failed to finish in TIMEOUT cycles
// BEHAVIOUR
//  - States: IDLE, ISSUE_M, ISSUE_D, WAIT_M, WAIT_D, WRITE, DONE, DZ, TMO. Moore outputs by state.
//  - Reset (reset==0 at posedge): state IDLE, counter 0. All outputs 0 while reset is low
//    and in IDLE.
//  - IDLE: start_mult=1 -> ISSUE_M (mult has priority when start_mult and start_div are both 1).
//    start_div=1, b_value!=0 -> ISSUE_D; start_div=1, b_value==0 -> DZ.
//  - ISSUE_M/ISSUE_D: init_mult/init_div=1 for exactly one cycle. Counter cleared.
//    Next state WAIT_M/WAIT_D.
//  - WAIT_x: counter increments each cycle.
//    Own done=1 -> WRITE. Other unit's done is ignored.
//    Otherwise, counter==TIMEOUT-1 -> TMO. done wins over timeout in the same cycle.
//  - done is accepted only in WAIT_x. A done pulse during ISSUE_x is ignored.
//  - WRITE: hi_write=lo_write=1 for one cycle -> DONE.
//  - DONE: op_done=1 for one cycle -> IDLE.
//  - DZ: div_by_zero=1 for one cycle, no init_div, no HI/LO write -> IDLE.
//  - TMO: timeout_err=1 for one cycle, no HI/LO write -> IDLE.
//  - Latency: start sampled at cycle 0; init at 1; done seen at cycle k (k>=2);
//    write at k+1, op_done at k+2, IDLE at k+3. A new start is accepted at k+3.
//  - start_* while busy=1 is ignored and not queued.
//  - abort=1 in any non-IDLE state -> IDLE next cycle.
//    Outputs of the current cycle still assert; e.g. abort during WRITE still writes HI/LO
//    but op_done never pulses. abort in IDLE has no effect, and start in that cycle
//    is still honoured.
//  - Reset low mid-operation forces IDLE at the next edge; no pulses afterwards.
//  - Counter saturates and never wraps; it is only meaningful in WAIT_x.
// TESTING
//  1. start_mult@0, mult_done@5 -> init_mult@1, hi/lo_write@6, op_done@7, busy 1..7, 0@8.
//  2. start_div, b_value=0 -> div_by_zero 1 cycle next; init_div, hi/lo_write, op_done stay 0.
//  3. start_div, b_value=7, div_done never -> init_div@1, timeout_err after TIMEOUT wait
//     cycles, no writes.
//  4. start_mult+start_div same cycle; start_div again while busy -> only mult runs,
//     div ignored.
//  5. abort during WAIT_D, then a late div_done -> IDLE next cycle, no write, no op_done.
//  6. reset low during WAIT_M; mult_done the cycle after release -> all outputs 0,
//     stays IDLE.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Sequences the shared multiplier/divider for the multicycle control unit:
// issues init pulses, waits on done, commits HI/LO and flags div-by-zero or a hung unit.
module muldiv_sequencer #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [31:0] b_value,
  input  logic        abort,
  input  logic        mult_done,
  input  logic        div_done,
  output logic        init_mult,
  output logic        init_div,
  output logic        hi_write,
  output logic        lo_write,
  output logic        busy,
  output logic        op_done,
  output logic        div_by_zero,
  output logic        timeout_err
);

  typedef enum logic [3:0] {
    IDLE,
    ISSUE_M,
    ISSUE_D,
    WAIT_M,
    WAIT_D,
    WRITE,
    DONE,
    DZ,
    TMO
  } stateT;

  localparam logic [CNT_W-1:0] cntLast = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] cntMax  = '1;

  stateT            state;
  stateT            nextState;
  logic [CNT_W-1:0] waitCnt;
  logic             waitExpired;

  assign waitExpired = (waitCnt >= cntLast);

  // Next-state selection; abort overrides everything once an operation is in flight.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (start_mult) begin
          nextState = ISSUE_M;
        end else if (start_div) begin
          nextState = (b_value == 32'd0) ? DZ : ISSUE_D;
        end
      end
      ISSUE_M: nextState = WAIT_M;
      ISSUE_D: nextState = WAIT_D;
      WAIT_M: begin
        if (mult_done) begin
          nextState = WRITE;
        end else if (waitExpired) begin
          nextState = TMO;
        end
      end
      WAIT_D: begin
        if (div_done) begin
          nextState = WRITE;
        end else if (waitExpired) begin
          nextState = TMO;
        end
      end
      WRITE:   nextState = DONE;
      DONE:    nextState = IDLE;
      DZ:      nextState = IDLE;
      TMO:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (abort && (state != IDLE)) begin
      nextState = IDLE;
    end
  end

  // State, wait counter and Moore outputs decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      waitCnt     <= '0;
      init_mult   <= 1'b0;
      init_div    <= 1'b0;
      hi_write    <= 1'b0;
      lo_write    <= 1'b0;
      busy        <= 1'b0;
      op_done     <= 1'b0;
      div_by_zero <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= nextState;
      if ((state == WAIT_M) || (state == WAIT_D)) begin
        if (waitCnt != cntMax) begin
          waitCnt <= waitCnt + CNT_W'(1);
        end
      end else begin
        waitCnt <= '0;
      end
      init_mult   <= (nextState == ISSUE_M);
      init_div    <= (nextState == ISSUE_D);
      hi_write    <= (nextState == WRITE);
      lo_write    <= (nextState == WRITE);
      busy        <= (nextState != IDLE);
      op_done     <= (nextState == DONE);
      div_by_zero <= (nextState == DZ);
      timeout_err <= (nextState == TMO);
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: a cycle-offset transaction model checks every output
// each cycle, and literal expectations pin the key latencies.
module tb_muldiv_sequencer;

  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 7;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_mult = 1'b0;
  logic        start_div = 1'b0;
  logic [31:0] b_value = 32'd0;
  logic        abort = 1'b0;
  logic        mult_done = 1'b0;
  logic        div_done = 1'b0;
  logic        init_mult, init_div, hi_write, lo_write;
  logic        busy, op_done, div_by_zero, timeout_err;

  int vectors = 0;
  int miscompares = 0;

  muldiv_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset(reset),
    .start_mult(start_mult),
    .start_div(start_div),
    .b_value(b_value),
    .abort(abort),
    .mult_done(mult_done),
    .div_done(div_done),
    .init_mult(init_mult),
    .init_div(init_div),
    .hi_write(hi_write),
    .lo_write(lo_write),
    .busy(busy),
    .op_done(op_done),
    .div_by_zero(div_by_zero),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Inputs are driven on the falling edge for one cycle, then outputs of the next cycle are visible.
  task automatic applyStimulus(input logic rst, input logic sm, input logic sd,
                               input logic [31:0] b, input logic ab,
                               input logic md, input logic dd);
    @(negedge clk);
    reset      = rst;
    start_mult = sm;
    start_div  = sd;
    b_value    = b;
    abort      = ab;
    mult_done  = md;
    div_done   = dd;
    @(posedge clk);
    #2;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Transaction model: kind 0=MULT, 1=DIV, 2=div-by-zero; mOff counts cycles since the start
  // was accepted, mDoneAt is the offset at which the own unit reported done (-1 if not yet).
  bit modelValid = 1'b0;
  bit mActive = 1'b0;
  int mKind = 0;
  int mOff = 0;
  int mDoneAt = -1;

  task automatic modelStep();
    bit ownDone;
    if (!reset) begin
      mActive    = 1'b0;
      modelValid = 1'b1;
    end else if (!mActive) begin
      if (start_mult) begin
        mActive = 1'b1; mKind = 0; mOff = 1; mDoneAt = -1;
      end else if (start_div) begin
        mActive = 1'b1; mKind = (b_value == 32'd0) ? 2 : 1; mOff = 1; mDoneAt = -1;
      end
    end else if (abort) begin
      mActive = 1'b0;
    end else begin
      ownDone = (mKind == 0) ? mult_done : div_done;
      if (mKind != 2 && mDoneAt < 0 && mOff >= 2 && mOff <= TIMEOUT + 1 && ownDone)
        mDoneAt = mOff;
      mOff++;
      if (mKind == 2 && mOff >= 2) mActive = 1'b0;
      else if (mDoneAt >= 0 && mOff >= mDoneAt + 3) mActive = 1'b0;
      else if (mDoneAt < 0 && mOff >= TIMEOUT + 3) mActive = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      modelStep();
      #1;
      if (modelValid) begin
        checkOutput("busy", busy, int'(mActive));
        checkOutput("init_mult", init_mult, int'(mActive && mKind == 0 && mOff == 1));
        checkOutput("init_div", init_div, int'(mActive && mKind == 1 && mOff == 1));
        checkOutput("div_by_zero", div_by_zero, int'(mActive && mKind == 2 && mOff == 1));
        checkOutput("hi_write", hi_write, int'(mActive && mDoneAt >= 0 && mOff == mDoneAt + 1));
        checkOutput("lo_write", lo_write, int'(mActive && mDoneAt >= 0 && mOff == mDoneAt + 1));
        checkOutput("op_done", op_done, int'(mActive && mDoneAt >= 0 && mOff == mDoneAt + 2));
        checkOutput("timeout_err", timeout_err,
                    int'(mActive && mKind != 2 && mDoneAt < 0 && mOff == TIMEOUT + 2));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got time %0t, expected < 200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;

    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'd5, 1'b0, 1'b1, 1'b1);
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.init_mult", init_mult, 0);
    checkOutput("reset.hi_write", hi_write, 0);
    idleCycle();

    // MULT, done at cycle 5
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("t1.c1.init_mult", init_mult, 1);
    checkOutput("t1.c1.busy", busy, 1);
    for (int i = 2; i <= 5; i++) begin
      idleCycle();
      checkOutput("t1.wait.busy", busy, 1);
      checkOutput("t1.wait.hi_write", hi_write, 0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("t1.c6.hi_write", hi_write, 1);
    checkOutput("t1.c6.lo_write", lo_write, 1);
    idleCycle();
    checkOutput("t1.c7.op_done", op_done, 1);
    checkOutput("t1.c7.busy", busy, 1);
    idleCycle();
    checkOutput("t1.c8.busy", busy, 0);

    // DIV by zero
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("t2.div_by_zero", div_by_zero, 1);
    checkOutput("t2.init_div", init_div, 0);
    idleCycle();
    checkOutput("t2.after.busy", busy, 0);
    checkOutput("t2.after.div_by_zero", div_by_zero, 0);

    // DIV that never finishes
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd7, 1'b0, 1'b0, 1'b0);
    checkOutput("t3.init_div", init_div, 1);
    cyc = 1;
    while (!timeout_err && cyc < 100) begin
      idleCycle();
      cyc++;
    end
    checkOutput("t3.timeout_cycle", cyc, TIMEOUT + 2);
    idleCycle();
    checkOutput("t3.after.busy", busy, 0);

    // DIV done on the last wait cycle beats the timeout
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd7, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= TIMEOUT; i++) idleCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("t3b.hi_write", hi_write, 1);
    checkOutput("t3b.timeout_err", timeout_err, 0);
    idleCycle();
    idleCycle();

    // simultaneous starts, DIV requested again while busy
    applyStimulus(1'b1, 1'b1, 1'b1, 32'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("t4.init_mult", init_mult, 1);
    checkOutput("t4.init_div", init_div, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd5, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd5, 1'b0, 1'b1, 1'b0);
    checkOutput("t4.hi_write", hi_write, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("t4.op_done", op_done, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("t4.c5.busy", busy, 0);
    idleCycle();
    checkOutput("t4.c6.init_div", init_div, 0);
    checkOutput("t4.c6.busy", busy, 0);

    // abort during WAIT_D, then a late div_done
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd3, 1'b0, 1'b0, 1'b0);
    idleCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("t5.busy", busy, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("t5.hi_write", hi_write, 0);
    idleCycle();
    checkOutput("t5.op_done", op_done, 0);

    // reset during WAIT_M, done after release
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("t6.reset.busy", busy, 0);
    idleCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("t6.hi_write", hi_write, 0);
    checkOutput("t6.busy", busy, 0);
    idleCycle();
    checkOutput("t6.op_done", op_done, 0);

    // abort in IDLE does not block a start; abort during WRITE still writes, no op_done
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("t7.init_mult", init_mult, 1);
    idleCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("t7.hi_write", hi_write, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("t7.op_done", op_done, 0);
    checkOutput("t7.busy", busy, 0);

    // done during ISSUE is ignored
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("t8.c2.hi_write", hi_write, 0);
    idleCycle();
    checkOutput("t8.c3.hi_write", hi_write, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("t8.busy", busy, 0);

    // normal DIV, the multiplier's done is ignored
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd9, 1'b0, 1'b0, 1'b0);
    checkOutput("t9.init_div", init_div, 1);
    idleCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("t9.c3.hi_write", hi_write, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("t9.c4.hi_write", hi_write, 1);
    idleCycle();
    checkOutput("t9.c5.op_done", op_done, 1);
    idleCycle();
    checkOutput("t9.c6.busy", busy, 0);

    idleCycle();
    idleCycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
